// File: rtl/noc_vc_inputc.sv
// Virtual-channel input unit: per-VC flit FIFOs, XY route computation on head flits,
// switch requests toward the allocator, registered flit output and upstream credit return.
module noc_vc_inputc #(
  parameter int VC_N    = 2,
  parameter int BUF_D   = 4,
  parameter int FLIT_W  = 32,
  parameter int COORD_W = 2,
  parameter int PORT_N  = 5,
  localparam int VCW    = (VC_N > 1) ? $clog2(VC_N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COORD_W-1:0]       my_xpos,
  input  logic [COORD_W-1:0]       my_ypos,
  input  logic                     valid_i,
  input  logic [VCW-1:0]           vc_i,
  input  logic [FLIT_W-1:0]        flit_i,
  output logic [VC_N-1:0]          req_o,
  output logic [VC_N*PORT_N-1:0]   port_o,
  input  logic [VC_N-1:0]          grant_i,
  output logic                     flit_valid_o,
  output logic [FLIT_W-1:0]        flit_o,
  output logic [VCW-1:0]           vc_o,
  output logic [VC_N-1:0]          credit_o,
  output logic                     err_o
);

  localparam int PTRW = $clog2(BUF_D);
  localparam int CNTW = $clog2(BUF_D + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [FLIT_W-1:0] mem [VC_N][BUF_D];
  logic [PTRW-1:0]   rd_ptr [VC_N];
  logic [PTRW-1:0]   wr_ptr [VC_N];
  logic [CNTW-1:0]   cnt_q  [VC_N];
  state_t            state_q [VC_N];
  state_t            state_d [VC_N];
  logic [PORT_N-1:0] route_q [VC_N];
  logic [PORT_N-1:0] route_d [VC_N];
  logic [FLIT_W-1:0] front   [VC_N];

  logic [VC_N-1:0] grant_hit, pop, purge, accept;
  logic            fire, drop, multi_grant;
  logic [VCW-1:0]  sel;

  logic              flit_valid_q;
  logic [FLIT_W-1:0] flit_q;
  logic [VCW-1:0]    vc_q;
  logic [VC_N-1:0]   credit_q;
  logic              err_q;

  function automatic logic [PORT_N-1:0] xy_route(
    input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] mx, input logic [COORD_W-1:0] my);
    logic [PORT_N-1:0] r;
    r = '0;
    if (dx > mx)      r[2] = 1'b1;
    else if (dx < mx) r[4] = 1'b1;
    else if (dy > my) r[1] = 1'b1;
    else if (dy < my) r[3] = 1'b1;
    else              r[0] = 1'b1;
    return r;
  endfunction

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(BUF_D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    req_o     = '0;
    port_o    = '0;
    grant_hit = '0;
    pop       = '0;
    purge     = '0;
    accept    = '0;
    fire      = 1'b0;
    sel       = '0;
    for (int unsigned v = 0; v < VC_N; v++) begin
      front[v]   = mem[v][rd_ptr[v]];
      state_d[v] = state_q[v];
      route_d[v] = route_q[v];
      req_o[v]   = (state_q[v] == ACTIVE) && (cnt_q[v] != '0);
      if (state_q[v] == ACTIVE) port_o[v*PORT_N +: PORT_N] = route_q[v];
    end
    // Lowest-index requesting VC wins when the grant is multi-hot.
    for (int unsigned v = 0; v < VC_N; v++) begin
      if (!fire && grant_i[v] && req_o[v]) begin
        fire         = 1'b1;
        sel          = VCW'(v);
        grant_hit[v] = 1'b1;
      end
    end
    for (int unsigned v = 0; v < VC_N; v++) begin
      if (state_q[v] == IDLE && cnt_q[v] != '0) begin
        if (front[v][FLIT_W-2]) begin
          route_d[v] = xy_route(front[v][COORD_W-1:0], front[v][2*COORD_W-1:COORD_W],
                                my_xpos, my_ypos);
          state_d[v] = ACTIVE;
        end else begin
          purge[v] = 1'b1;
        end
      end
      if (grant_hit[v] && front[v][FLIT_W-1]) state_d[v] = IDLE;
      pop[v] = grant_hit[v] | purge[v];
      accept[v] = valid_i && (vc_i == VCW'(v)) &&
                  ((cnt_q[v] < CNTW'(BUF_D)) || pop[v]);
    end
    drop        = valid_i && (accept == '0);
    multi_grant = (grant_i & (grant_i - VC_N'(1))) != '0;
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < VC_N; v++)
      if (accept[v]) mem[v][wr_ptr[v]] <= flit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < VC_N; v++) begin
        state_q[v] <= IDLE;
        rd_ptr[v]  <= '0;
        wr_ptr[v]  <= '0;
        cnt_q[v]   <= '0;
        route_q[v] <= '0;
      end
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      vc_q         <= '0;
      credit_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VC_N; v++) begin
        state_q[v] <= state_d[v];
        route_q[v] <= route_d[v];
        if (accept[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (pop[v])    rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        case ({accept[v], pop[v]})
          2'b10:   cnt_q[v] <= cnt_q[v] + CNTW'(1);
          2'b01:   cnt_q[v] <= cnt_q[v] - CNTW'(1);
          default: cnt_q[v] <= cnt_q[v];
        endcase
      end
      flit_valid_q <= fire;
      if (fire) begin
        flit_q <= front[sel];
        vc_q   <= sel;
      end
      credit_q <= grant_hit;
      if (drop || multi_grant || (purge != '0)) err_q <= 1'b1;
    end
  end

  assign flit_valid_o = flit_valid_q;
  assign flit_o       = flit_q;
  assign vc_o         = vc_q;
  assign credit_o     = credit_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_noc_vc_inputc.sv
// Directed self-checking bench for noc_vc_inputc (VC_N=2, BUF_D=4, FLIT_W=32, COORD_W=2).
module tb_noc_vc_inputc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  my_xpos, my_ypos;
  logic        valid_i;
  logic [0:0]  vc_i;
  logic [31:0] flit_i;
  logic [1:0]  req_o;
  logic [9:0]  port_o;
  logic [1:0]  grant_i;
  logic        flit_valid_o;
  logic [31:0] flit_o;
  logic [0:0]  vc_o;
  logic [1:0]  credit_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] TB = 2'b00, TH = 2'b01, TT = 2'b10, THT = 2'b11;

  noc_vc_inputc #(.VC_N(2), .BUF_D(4), .FLIT_W(32), .COORD_W(2), .PORT_N(5)) dut (
    .clk(clk), .rst(rst), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .valid_i(valid_i), .vc_i(vc_i), .flit_i(flit_i),
    .req_o(req_o), .port_o(port_o), .grant_i(grant_i),
    .flit_valid_o(flit_valid_o), .flit_o(flit_o), .vc_o(vc_o),
    .credit_o(credit_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkf(input logic [1:0] t, input logic [25:0] p,
                                      input logic [1:0] dx, input logic [1:0] dy);
    return {t, p, dy, dx};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] f, input logic v,
                         input logic [1:0] cr);
    chk({tag, "_valid"}, 64'(flit_valid_o), 64'(1'b1));
    chk({tag, "_flit"}, 64'(flit_o), 64'(f));
    chk({tag, "_vc"}, 64'(vc_o), 64'(v));
    chk({tag, "_credit"}, 64'(credit_o), 64'(cr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [31:0] h, b1, b2, b3, t, h0, h1, t0, t1;

  initial begin
    rst = 1'b1; valid_i = 1'b0; vc_i = '0; flit_i = '0; grant_i = '0;
    my_xpos = 2'd1; my_ypos = 2'd1;
    #12;
    chk("rst_req", 64'(req_o), 64'(0));
    chk("rst_port", 64'(port_o), 64'(0));
    chk("rst_fv", 64'(flit_valid_o), 64'(0));
    chk("rst_flit", 64'(flit_o), 64'(0));
    chk("rst_vc", 64'(vc_o), 64'(0));
    chk("rst_credit", 64'(credit_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // single-flit packet east
    h = mkf(THT, 26'h11, 2'd3, 2'd1);
    valid_i = 1'b1; vc_i = 1'b0; flit_i = h;
    step(); valid_i = 1'b0;
    chk("t1_rc_noreq", 64'(req_o), 64'(0));
    step();
    chk("t1_req", 64'(req_o), 64'(2'b01));
    chk("t1_port", 64'(port_o), 64'(10'b00000_00100));
    grant_i = 2'b01;
    step(); grant_i = 2'b00;
    chk_out("t1_out", h, 1'b0, 2'b01);
    chk("t1_idle_req", 64'(req_o), 64'(0));
    chk("t1_idle_port", 64'(port_o), 64'(0));
    step();
    chk("t1_fv_low", 64'(flit_valid_o), 64'(0));
    chk("t1_cr_low", 64'(credit_o), 64'(0));

    // 4-flit packet south on VC1, grant held
    my_xpos = 2'd2; my_ypos = 2'd2; grant_i = 2'b10;
    h = mkf(TH, 26'h21, 2'd2, 2'd0); b1 = mkf(TB, 26'h22, 2'd0, 2'd0);
    b2 = mkf(TB, 26'h23, 2'd0, 2'd0); t = mkf(TT, 26'h24, 2'd0, 2'd0);
    valid_i = 1'b1; vc_i = 1'b1; flit_i = h;
    step(); flit_i = b1;
    step();
    chk("t2_req", 64'(req_o), 64'(2'b10));
    chk("t2_port", 64'(port_o), 64'(10'b01000_00000));
    flit_i = b2;
    step(); chk_out("t2_f0", h, 1'b1, 2'b10);
    flit_i = t;
    step(); valid_i = 1'b0; chk_out("t2_f1", b1, 1'b1, 2'b10);
    step(); chk_out("t2_f2", b2, 1'b1, 2'b10);
    step(); chk_out("t2_f3", t, 1'b1, 2'b10);
    chk("t2_req_done", 64'(req_o), 64'(0));
    step();
    chk("t2_fv_low", 64'(flit_valid_o), 64'(0));
    grant_i = 2'b00;

    // interleaved packets: VC0 west, VC1 local
    h0 = mkf(TH, 26'h31, 2'd0, 2'd2); h1 = mkf(TH, 26'h32, 2'd2, 2'd2);
    t0 = mkf(TT, 26'h33, 2'd1, 2'd1); t1 = mkf(TT, 26'h34, 2'd3, 2'd3);
    valid_i = 1'b1; vc_i = 1'b0; flit_i = h0; step();
    vc_i = 1'b1; flit_i = h1; step();
    vc_i = 1'b0; flit_i = t0; step();
    vc_i = 1'b1; flit_i = t1; step();
    valid_i = 1'b0;
    chk("t3_req", 64'(req_o), 64'(2'b11));
    chk("t3_port", 64'(port_o), 64'(10'b00001_10000));
    grant_i = 2'b01; step(); chk_out("t3_h0", h0, 1'b0, 2'b01);
    chk("t3_req_b", 64'(req_o), 64'(2'b11));
    grant_i = 2'b10; step(); chk_out("t3_h1", h1, 1'b1, 2'b10);
    chk("t3_port_b", 64'(port_o), 64'(10'b00001_10000));
    grant_i = 2'b01; step(); chk_out("t3_t0", t0, 1'b0, 2'b01);
    chk("t3_req_c", 64'(req_o), 64'(2'b10));
    grant_i = 2'b10; step(); chk_out("t3_t1", t1, 1'b1, 2'b10);
    chk("t3_req_d", 64'(req_o), 64'(0));
    chk("t3_err", 64'(err_o), 64'(0));
    grant_i = 2'b00;

    // overflow: 5th flit with no grant is dropped
    do_reset();
    h = mkf(TH, 26'h41, 2'd3, 2'd2); b1 = mkf(TB, 26'h42, 2'd0, 2'd0);
    b2 = mkf(TB, 26'h43, 2'd0, 2'd0); b3 = mkf(TB, 26'h44, 2'd0, 2'd0);
    t = mkf(TT, 26'h45, 2'd0, 2'd0);
    valid_i = 1'b1; vc_i = 1'b0;
    flit_i = h; step(); flit_i = b1; step(); flit_i = b2; step(); flit_i = b3; step();
    chk("t4_err_full", 64'(err_o), 64'(0));
    flit_i = t; step(); valid_i = 1'b0;
    chk("t4_err_drop", 64'(err_o), 64'(1));
    // same again with a grant on the 5th write: pass-through at full
    do_reset();
    valid_i = 1'b1; vc_i = 1'b0;
    flit_i = h; step(); flit_i = b1; step(); flit_i = b2; step(); flit_i = b3; step();
    flit_i = t; grant_i = 2'b01; step(); valid_i = 1'b0;
    chk("t4_err_pass", 64'(err_o), 64'(0));
    chk_out("t4_f0", h, 1'b0, 2'b01);
    step(); chk_out("t4_f1", b1, 1'b0, 2'b01);
    step(); chk_out("t4_f2", b2, 1'b0, 2'b01);
    step(); chk_out("t4_f3", b3, 1'b0, 2'b01);
    step(); chk_out("t4_f4", t, 1'b0, 2'b01);
    chk("t4_req_done", 64'(req_o), 64'(0));
    chk("t4_err_end", 64'(err_o), 64'(0));
    grant_i = 2'b00;

    // stale body on an idle VC is purged
    valid_i = 1'b1; vc_i = 1'b1; flit_i = mkf(TB, 26'h51, 2'd1, 2'd1);
    step(); valid_i = 1'b0;
    chk("t5_err_pre", 64'(err_o), 64'(0));
    step();
    chk("t5_err", 64'(err_o), 64'(1));
    chk("t5_credit", 64'(credit_o), 64'(0));
    chk("t5_fv", 64'(flit_valid_o), 64'(0));
    chk("t5_req", 64'(req_o), 64'(0));
    h = mkf(THT, 26'h52, 2'd3, 2'd2);
    valid_i = 1'b1; vc_i = 1'b1; flit_i = h; step(); valid_i = 1'b0;
    step();
    chk("t5_req_h", 64'(req_o), 64'(2'b10));
    chk("t5_port_h", 64'(port_o), 64'(10'b00100_00000));
    grant_i = 2'b10; step(); grant_i = 2'b00;
    chk_out("t5_out", h, 1'b1, 2'b10);

    // async reset mid-packet
    do_reset();
    my_xpos = 2'd1; my_ypos = 2'd1; grant_i = 2'b01;
    h = mkf(TH, 26'h61, 2'd1, 2'd3); b1 = mkf(TB, 26'h62, 2'd0, 2'd0);
    b2 = mkf(TB, 26'h63, 2'd0, 2'd0); t = mkf(TT, 26'h64, 2'd0, 2'd0);
    valid_i = 1'b1; vc_i = 1'b0;
    flit_i = h; step(); flit_i = b1; step();
    chk("t6_port", 64'(port_o), 64'(10'b00000_00010));
    flit_i = b2; step(); chk_out("t6_f0", h, 1'b0, 2'b01);
    flit_i = t; step(); valid_i = 1'b0; grant_i = 2'b00;
    chk_out("t6_f1", b1, 1'b0, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_fv", 64'(flit_valid_o), 64'(0));
    chk("t6_rst_flit", 64'(flit_o), 64'(0));
    chk("t6_rst_vc", 64'(vc_o), 64'(0));
    chk("t6_rst_credit", 64'(credit_o), 64'(0));
    chk("t6_rst_req", 64'(req_o), 64'(0));
    chk("t6_rst_port", 64'(port_o), 64'(0));
    chk("t6_rst_err", 64'(err_o), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    step(); step();
    chk("t6_nostale_req", 64'(req_o), 64'(0));
    chk("t6_nostale_fv", 64'(flit_valid_o), 64'(0));
    h = mkf(THT, 26'h65, 2'd0, 2'd1);
    valid_i = 1'b1; vc_i = 1'b0; flit_i = h; step(); valid_i = 1'b0;
    step();
    chk("t6_new_req", 64'(req_o), 64'(2'b01));
    chk("t6_new_port", 64'(port_o), 64'(10'b00000_10000));
    grant_i = 2'b01; step(); grant_i = 2'b00;
    chk_out("t6_new_out", h, 1'b0, 2'b01);
    step();
    chk("t6_empty_req", 64'(req_o), 64'(0));
    chk("t6_err_end", 64'(err_o), 64'(0));

    // multi-hot grant: lowest requesting VC serviced, error flagged
    h0 = mkf(THT, 26'h71, 2'd1, 2'd1); h1 = mkf(THT, 26'h72, 2'd1, 2'd0);
    valid_i = 1'b1; vc_i = 1'b0; flit_i = h0; step();
    vc_i = 1'b1; flit_i = h1; step(); valid_i = 1'b0;
    step();
    chk("t7_req", 64'(req_o), 64'(2'b11));
    chk("t7_port", 64'(port_o), 64'(10'b01000_00001));
    grant_i = 2'b11; step();
    chk_out("t7_v0", h0, 1'b0, 2'b01);
    chk("t7_err", 64'(err_o), 64'(1));
    chk("t7_req_b", 64'(req_o), 64'(2'b10));
    grant_i = 2'b10; step(); grant_i = 2'b00;
    chk_out("t7_v1", h1, 1'b1, 2'b10);
    step();
    chk("t7_req_done", 64'(req_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
